// File: rtl/instr_mem_arbiter.sv
// rtl/instr_mem_arbiter.sv - merges core fetch and loader ports onto one single-cycle-latency RAM port
module instr_mem_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int MAX_STALL  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    input  logic                  ld_req_i,
    input  logic                  ld_we_i,
    input  logic [31:0]           ld_addr_i,
    input  logic [31:0]           ld_wdata_i,
    input  logic [3:0]            ld_be_i,
    output logic                  ld_gnt_o,
    output logic                  ld_rvalid_o,
    output logic [31:0]           ld_rdata_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam int CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_CORE,
        OWN_LD
    } owner_t;

    owner_t           r_owner;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_force_ld;
    logic w_instr_gnt;
    logic w_ld_gnt;
    logic w_unused_addr;

    // Core has priority until the loader has been refused MAX_STALL cycles in a row.
    assign w_force_ld  = ld_req_i & (r_stall_cnt == STALL_MAX);
    assign w_instr_gnt = rst_n & instr_req_i & ~w_force_ld;
    assign w_ld_gnt    = rst_n & ld_req_i & (~instr_req_i | w_force_ld);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner     <= OWN_IDLE;
            r_stall_cnt <= '0;
        end else begin
            if (w_instr_gnt) begin
                r_owner <= OWN_CORE;
            end else if (w_ld_gnt) begin
                r_owner <= OWN_LD;
            end else begin
                r_owner <= OWN_IDLE;
            end

            if (ld_req_i & ~w_ld_gnt) begin
                if (r_stall_cnt != STALL_MAX) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    assign instr_gnt_o = w_instr_gnt;
    assign ld_gnt_o    = w_ld_gnt;

    assign ram_en_o    = w_instr_gnt | w_ld_gnt;
    assign ram_we_o    = w_ld_gnt & ld_we_i;
    assign ram_addr_o  = !rst_n   ? '0 :
                         w_ld_gnt ? ld_addr_i[ADDR_WIDTH-1:0] : instr_addr_i[ADDR_WIDTH-1:0];
    assign ram_wdata_o = rst_n ? ld_wdata_i : 32'h0;
    assign ram_be_o    = !rst_n   ? 4'h0 :
                         w_ld_gnt ? ld_be_i : 4'hF;

    // An outstanding response is dropped if reset lands before it is delivered.
    assign instr_rvalid_o = rst_n & (r_owner == OWN_CORE);
    assign ld_rvalid_o    = rst_n & (r_owner == OWN_LD);
    assign instr_rdata_o  = rst_n ? ram_rdata_i : 32'h0;
    assign ld_rdata_o     = rst_n ? ram_rdata_i : 32'h0;

    assign w_unused_addr = ^{instr_addr_i[31:ADDR_WIDTH], ld_addr_i[31:ADDR_WIDTH]};

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// tb/tb_instr_mem_arbiter.sv - self-checking bench for instr_mem_arbiter
module tb_instr_mem_arbiter;

    localparam int AW = 17;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_req_i;
    logic [31:0]   instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          ld_req_i;
    logic          ld_we_i;
    logic [31:0]   ld_addr_i;
    logic [31:0]   ld_wdata_i;
    logic [3:0]    ld_be_i;
    logic          ld_gnt_o;
    logic          ld_rvalid_o;
    logic [31:0]   ld_rdata_o;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   ram_rdata_i;

    int checks = 0;
    int errors = 0;

    instr_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_STALL(MS)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
        .ld_be_i(ld_be_i), .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: consecutive refusals seen by the loader, and who owns the response in flight.
    int m_refused = 0;
    int m_owner   = 0;   // 0 none, 1 core, 2 loader

    always @(negedge clk) begin
        bit          force_ld, e_ig, e_lg;
        logic [31:0] e_addr;
        force_ld = ld_req_i && (m_refused >= MS);
        e_ig     = rst_n && instr_req_i && !force_ld;
        e_lg     = rst_n && ld_req_i && (!instr_req_i || force_ld);
        e_addr   = (e_lg ? ld_addr_i : instr_addr_i) % (32'd1 << AW);

        chk("m_instr_gnt", 32'(instr_gnt_o), 32'(e_ig));
        chk("m_ld_gnt", 32'(ld_gnt_o), 32'(e_lg));
        chk("m_ram_en", 32'(ram_en_o), 32'(e_ig || e_lg));
        chk("m_ram_we", 32'(ram_we_o), 32'(e_lg && ld_we_i));
        chk("m_instr_rvalid", 32'(instr_rvalid_o), 32'(rst_n && m_owner == 1));
        chk("m_ld_rvalid", 32'(ld_rvalid_o), 32'(rst_n && m_owner == 2));
        if (e_ig || e_lg) begin
            chk("m_ram_addr", 32'(ram_addr_o), e_addr);
            chk("m_ram_be", 32'(ram_be_o), e_lg ? 32'(ld_be_i) : 32'hF);
        end
        if (e_lg) chk("m_ram_wdata", ram_wdata_o, ld_wdata_i);
        if (rst_n && m_owner == 1) chk("m_instr_rdata", instr_rdata_o, ram_rdata_i);
        if (rst_n && m_owner == 2 && !ld_we_i) chk("m_ld_rdata", ld_rdata_o, ram_rdata_i);
        if (!rst_n) begin
            chk("m_rst_addr", 32'(ram_addr_o), 32'h0);
            chk("m_rst_wdata", ram_wdata_o, 32'h0);
            chk("m_rst_be", 32'(ram_be_o), 32'h0);
            chk("m_rst_rdata", instr_rdata_o | ld_rdata_o, 32'h0);
        end

        if (!rst_n) begin
            m_owner   = 0;
            m_refused = 0;
        end else begin
            m_owner   = e_ig ? 1 : (e_lg ? 2 : 0);
            m_refused = (ld_req_i && !e_lg) ? ((m_refused + 1 > MS) ? MS : m_refused + 1) : 0;
        end
    end

    task automatic step(input logic ireq, input logic [31:0] iaddr,
                        input logic lreq, input logic lwe, input logic [31:0] laddr,
                        input logic [31:0] lwdata, input logic [3:0] lbe, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        ld_req_i     = lreq;
        ld_we_i      = lwe;
        ld_addr_i    = laddr;
        ld_wdata_i   = lwdata;
        ld_be_i      = lbe;
        ram_rdata_i  = rdata;
    endtask

    task automatic idle(input logic [31:0] rdata);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdata);
    endtask

    logic [31:0] gv;
    logic [31:0] iv;

    initial begin
        rst_n        = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        ld_req_i     = 1'b0;
        ld_we_i      = 1'b0;
        ld_addr_i    = 32'h0;
        ld_wdata_i   = 32'h0;
        ld_be_i      = 4'h0;
        ram_rdata_i  = 32'h0;
        repeat (3) idle(32'h0);
        rst_n = 1'b1;
        #1;
        chk("reset_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("reset_ld_rvalid", 32'(ld_rvalid_o), 32'h0);

        // Single fetch
        step(1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("fetch_gnt", 32'(instr_gnt_o), 32'h1);
        chk("fetch_addr", 32'(ram_addr_o), 32'h0104);
        idle(32'hDEADBEEF);
        #1;
        chk("fetch_rvalid", 32'(instr_rvalid_o), 32'h1);
        chk("fetch_rdata", instr_rdata_o, 32'hDEADBEEF);
        chk("fetch_ld_rvalid", 32'(ld_rvalid_o), 32'h0);

        // Streaming: three back-to-back fetches
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        for (int i = 1; i < 4; i++) begin
            if (i < 3) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_0000 + 32'(i));
            else idle(32'h1111_0003);
            #1;
            chk("stream_rvalid", 32'(instr_rvalid_o), 32'h1);
            chk("stream_rdata", instr_rdata_o, 32'h1111_0000 + 32'(i));
        end

        // Loader write
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200, 32'hA5A5A5A5, 4'h3, 32'h0);
        #1;
        chk("wr_we", 32'(ram_we_o), 32'h1);
        chk("wr_be", 32'(ram_be_o), 32'h3);
        chk("wr_wdata", ram_wdata_o, 32'hA5A5A5A5);
        idle(32'h0);
        #1;
        chk("wr_ld_rvalid", 32'(ld_rvalid_o), 32'h1);
        chk("wr_instr_rvalid", 32'(instr_rvalid_o), 32'h0);

        // Loader read
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0208, 32'h0, 4'hF, 32'h0);
        idle(32'h0BADF00D);
        #1;
        chk("rd_ld_rdata", ld_rdata_o, 32'h0BADF00D);

        // Starvation: both request continuously
        gv = 32'h0;
        iv = 32'h0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h2222_0000 + 32'(i));
            #1;
            gv[i] = ld_gnt_o;
            iv[i] = instr_gnt_o;
        end
        chk("starve_ld_pattern", gv, 32'h210);
        chk("starve_core_pattern", iv, 32'h1EF);
        idle(32'h0);
        idle(32'h0);

        // Loader drops while refused: credit is lost
        gv = 32'h0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 32'h500, (i != 3), 1'b0, 32'h600, 32'h0, 4'hF, 32'h3333_0000 + 32'(i));
            #1;
            gv[i] = ld_gnt_o;
        end
        chk("drop_ld_pattern", gv, 32'h100);
        idle(32'h0);

        // Truncation into boot region
        step(1'b1, 32'h1A01_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("trunc_addr", 32'(ram_addr_o), 32'h1_0000);
        idle(32'h0);

        // Reset mid-operation
        step(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rst_pre_gnt", 32'(instr_gnt_o), 32'h1);
        step(1'b1, 32'h704, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h4444_4444);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(instr_gnt_o), 32'h0);
        chk("rst_en", 32'(ram_en_o), 32'h0);
        chk("rst_rvalid", 32'(instr_rvalid_o), 32'h0);
        step(1'b1, 32'h704, 1'b1, 1'b0, 32'h800, 32'h0, 4'hF, 32'h0);
        #1;
        chk("rst_hold_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("rst_hold_ld_gnt", 32'(ld_gnt_o), 32'h0);
        gv = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h704, 1'b1, 1'b0, 32'h800, 32'h0, 4'hF, 32'h5555_0000 + 32'(i));
            rst_n = 1'b1;
            #1;
            gv[i] = ld_gnt_o;
        end
        chk("rst_release_pattern", gv, 32'h10);

        repeat (3) idle(32'h0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
